// File: rtl/arb_mux.sv
// arb_mux: N_CH-to-1 valid/ready multiplexer with a single registered output
// slot. The grant comes either from a fixed channel select (mode = 0) or from
// a round-robin arbiter whose search starts at ptr (mode = 1).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel select for mode 0
//   in_valid   per-channel valid
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept (one-hot or zero)
//   out_valid  output slot holds data
//   out_data   registered data of the granted channel
//   out_ch     index of the channel that supplied out_data
//   out_ready  downstream accept
module arb_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] idx;
  logic             gnt_vld;
  logic             load_en;
  logic             grant_ok;
  logic             take;
  logic [WIDTH-1:0] gnt_data;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;

  // ---- stage p0: grant decision and input handshake (combinational) ----

  // Round-robin scan runs from the highest offset down so the channel closest
  // to ptr is the last (and therefore winning) assignment. ptr + k wraps in
  // SEL_W bits, which is modulo N_CH because N_CH is a power of two.
  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b1;
    idx     = '0;
    if (mode) begin
      gnt     = ptr;
      gnt_vld = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = ptr + SEL_W'(k);
        if (in_valid[idx]) begin
          gnt     = idx;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign load_en  = !vld_p1 || out_ready;
  // rst_n gates the handshake so nothing is offered while reset is held.
  assign grant_ok = gnt_vld && load_en && rst_n;
  assign take     = grant_ok && in_valid[gnt];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = grant_ok && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- stage p1: output slot and round-robin pointer ----

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else begin
      if (take) begin
        vld_p1  <= 1'b1;
        data_p1 <= gnt_data;
        ch_p1   <= gnt;
        if (mode) ptr <= gnt + SEL_W'(1);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a 4x8 instance (A) and an 8x16 instance (B) run side by
// side against a transaction-level model of the grant rules and output slot.
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         a_mode, a_or, a_ov;
  logic [1:0]   a_sel, a_oc;
  logic [3:0]   a_iv, a_ir;
  logic [31:0]  a_id;
  logic [7:0]   a_od;

  logic         b_mode, b_or, b_ov;
  logic [2:0]   b_sel, b_oc;
  logic [7:0]   b_iv, b_ir;
  logic [127:0] b_id;
  logic [15:0]  b_od;

  arb_mux #(.WIDTH(8), .N_CH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel), .in_valid(a_iv),
    .in_data(a_id), .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od),
    .out_ch(a_oc), .out_ready(a_or));

  arb_mux #(.WIDTH(16), .N_CH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .in_valid(b_iv),
    .in_data(b_id), .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od),
    .out_ch(b_oc), .out_ready(b_or));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model state: index 0 = instance A, 1 = instance B
  int          m_vld[2];
  logic [31:0] m_data[2];
  int          m_ch[2];
  int          m_ptr[2];

  function automatic int grant(int n, int mode, int sel, int ptr, logic [15:0] v);
    if (mode == 0) return sel;
    for (int k = 0; k < n; k++) if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_vld[j] = 0; m_data[j] = 0; m_ch[j] = 0; m_ptr[j] = 0;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int ga, gb;
    logic [31:0] era, erb;
    bit ta, tb;
    logic [31:0] da, db;
    #1;
    ga  = grant(4, a_mode, a_sel, m_ptr[0], {12'b0, a_iv});
    gb  = grant(8, b_mode, b_sel, m_ptr[1], {8'b0, b_iv});
    era = (rst_n && ga >= 0 && (!m_vld[0] || a_or)) ? (32'd1 << ga) : 32'd0;
    erb = (rst_n && gb >= 0 && (!m_vld[1] || b_or)) ? (32'd1 << gb) : 32'd0;
    chk("a_in_ready", a_ir, era);
    chk("b_in_ready", b_ir, erb);
    ta = (era != 0) && a_iv[ga];
    tb = (erb != 0) && b_iv[gb];
    da = (ga >= 0) ? a_id[ga*8 +: 8] : 0;
    db = (gb >= 0) ? b_id[gb*16 +: 16] : 0;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (ta) begin
        m_vld[0] = 1; m_data[0] = da; m_ch[0] = ga;
        if (a_mode) m_ptr[0] = (ga + 1) % 4;
      end else if (a_or) m_vld[0] = 0;
      if (tb) begin
        m_vld[1] = 1; m_data[1] = db; m_ch[1] = gb;
        if (b_mode) m_ptr[1] = (gb + 1) % 8;
      end else if (b_or) m_vld[1] = 0;
    end
    #1;
    chk("a_out_valid", a_ov, m_vld[0]);
    chk("a_out_data",  a_od, m_data[0]);
    chk("a_out_ch",    a_oc, m_ch[0]);
    chk("b_out_valid", b_ov, m_vld[1]);
    chk("b_out_data",  b_od, m_data[1]);
    chk("b_out_ch",    b_oc, m_ch[1]);
    @(negedge clk);
  endtask

  task automatic rand_a();
    a_mode = 1'($urandom); a_sel = 2'($urandom); a_iv = 4'($urandom);
    a_id = $urandom; a_or = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rand_b();
    b_mode = 1'($urandom); b_sel = 3'($urandom); b_iv = 8'($urandom);
    b_id = {$urandom, $urandom, $urandom, $urandom};
    b_or = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [7:0]  hold_d;
    logic [1:0]  hold_c;
    rst_n = 1'b0;
    a_mode = 0; a_sel = 0; a_iv = 0; a_id = 0; a_or = 0;
    b_mode = 0; b_sel = 0; b_iv = 0; b_id = 0; b_or = 1;
    model_reset();
    @(negedge clk);
    tick();
    chk("rst_a_ov", a_ov, 0);
    chk("rst_a_ir", a_ir, 0);
    rst_n = 1'b1;

    // Fixed select: sel=2 with all channels valid
    a_mode = 0; a_sel = 2; a_iv = 4'b1111; a_id = 32'h11A5_2233; a_or = 1;
    #1 chk("fix_ready", a_ir, 4'b0100);
    tick();
    chk("fix_valid", a_ov, 1);
    chk("fix_data",  a_od, 8'hA5);
    chk("fix_ch",    a_oc, 2);

    // Round-robin fairness from ptr = 0
    a_mode = 1; a_iv = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      a_id = $urandom;
      tick();
      chk("rr_seq_ch", a_oc, i % 4);
    end
    tick();                           // grant 2, ptr -> 3
    chk("rr_pre_ch", a_oc, 2);
    a_iv = 4'b0010;                   // skip 3, wrap to 1
    tick();
    chk("rr_skip_ch", a_oc, 1);
    a_iv = 4'b0110;                   // ptr now 2: ch2 must win over ch1
    tick();
    chk("rr_ptr2_ch", a_oc, 2);

    // Backpressure: slot full, downstream stalled, inputs changing
    a_iv = 4'b1111; a_or = 0;
    tick();
    hold_d = a_od; hold_c = a_oc;
    for (int i = 0; i < 5; i++) begin
      a_mode = 1'($urandom); a_sel = 2'($urandom); a_iv = 4'($urandom) | 4'b0001;
      a_id = $urandom;
      tick();
      chk("bp_ready", a_ir, 0);
      chk("bp_data",  a_od, hold_d);
      chk("bp_ch",    a_oc, hold_c);
    end
    a_or = 1; a_mode = 0; a_sel = 3; a_iv = 4'b1000; a_id = 32'h5A00_0000;
    tick();
    chk("bp_reload_v",  a_ov, 1);
    chk("bp_reload_d",  a_od, 8'h5A);

    // Asynchronous reset between edges while the slot is full
    a_or = 0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", a_ov, 0);
    chk("arst_od", a_od, 0);
    chk("arst_oc", a_oc, 0);
    chk("arst_ir", a_ir, 0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    a_mode = 1; a_iv = 4'b1111; a_or = 1;
    tick();
    chk("post_rst_ch", a_oc, 0);

    // 8x16 instance, channels 0 and 7 competing
    b_mode = 1; b_iv = 8'b1000_0001; b_or = 1;
    for (int i = 0; i < 4; i++) begin
      b_id = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("wide_alt_ch", b_oc, (i % 2) ? 7 : 0);
    end

    // Randomised traffic on both instances
    for (int i = 0; i < 400; i++) begin
      rand_a();
      rand_b();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits per channel.
REQ-002 SHALL have parameter N_CH, default 4, channel count; legal values 2, 4, 8, 16 (power of two).
REQ-003 SHALL have derived localparam SEL_W = clog2(N_CH), default 2.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel select, used only when mode = 0.
REQ-008 in_valid  input  N_CH  per-channel data valid.
REQ-009 in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  N_CH  per-channel accept; transfer on channel i when in_valid[i] and in_ready[i] both high at a clock edge.
REQ-011 out_valid  output  1  registered output holds valid data.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_ch  output  SEL_W  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept; output transfer when out_valid and out_ready both high.

Function
REQ-015 SHALL contain one output register slot (out_valid/out_data/out_ch); load_en = !out_valid || out_ready.
REQ-016 Grant g, mode 0: g = sel, regardless of in_valid.
REQ-017 Grant g, mode 1: first index with in_valid high, scanning ptr, ptr+1, ..., wrapping modulo N_CH; no grant if all in_valid low.
REQ-018 in_ready[i] SHALL be high only when i = g, a grant exists, and load_en is high; all other bits low.
REQ-019 On a transfer from channel g: out_data <= in_data[g], out_ch <= g, out_valid <= 1; latency input-to-output exactly 1 cycle.
REQ-020 If out_valid && out_ready and no input transfer occurs, out_valid SHALL clear at that edge; out_data/out_ch hold their values.
REQ-021 Simultaneous output drain and input load SHALL both occur in the same cycle; sustained throughput 1 word/cycle.
REQ-022 While out_valid && !out_ready, out_data and out_ch SHALL remain stable and all in_ready SHALL be low.
REQ-023 Round-robin pointer ptr (SEL_W bits): after a mode-1 transfer from g, ptr <= (g+1) mod N_CH; wrap from N_CH-1 to 0.
REQ-024 ptr SHALL not change on cycles without a transfer, or on mode-0 transfers.
REQ-025 mode or sel changes SHALL affect only the next grant decision; data already in the output register is unaffected.
REQ-026 in_ready SHALL be combinational from mode, sel, in_valid, ptr, out_valid, out_ready; no combinational path from in_data.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-028 Reset mid-operation SHALL discard held data; all in_ready low while rst_n low.
REQ-029 After rst_n deasserts, first grant decision uses ptr = 0.

Verification
REQ-030 Reset: assert rst_n = 0 between clock edges with out_valid = 1 -> out_valid, out_data, out_ch read 0 before next edge.
REQ-031 Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2; in_ready=4'b0100.
REQ-032 Round-robin fairness: mode=1, all four valid constantly, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-033 Round-robin skip/wrap: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2 after transfer.
REQ-034 Backpressure: out_ready=0 with out_valid=1 for 5 cycles while inputs change -> out_data/out_ch constant, in_ready=0; raising out_ready with input valid gives drain and load on the same edge.
REQ-035 Parameter sweep: N_CH=8, WIDTH=16, mode=1, in_valid=8'b1000_0001 -> alternating out_ch 0,7,0,7 with matching 16-bit data.
